// File: rtl/ldo_mode_ctrl.sv
// ldo_mode_ctrl: coarse/settle/fine/handoff loop-mode controller for the LDO shift-register array
module ldo_mode_ctrl #(
  parameter int L        = 16,
  parameter int M        = 16,
  parameter int TOGGLE_N = 3,
  parameter int SAT_N    = 2,
  parameter int SETTLE_N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         comp_in,
  input  logic [L-1:0] fine_out,
  input  logic [M-1:0] coarse_out,
  output logic         fine_en,
  output logic         coarse_en,
  output logic         up,
  output logic         lock,
  output logic         rail,
  output logic [1:0]   state
);
  localparam int TW = $clog2(TOGGLE_N + 1);
  localparam int SW = $clog2(SETTLE_N + 1);
  localparam int AW = $clog2(SAT_N + 1);
  localparam logic [TW-1:0] TOG_MAX  = TW'(TOGGLE_N);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_N - 1);
  localparam logic [AW-1:0] SAT_MAX  = AW'(SAT_N);
  typedef enum logic [1:0] {COARSE = 2'b00, SETTLE = 2'b01, FINE = 2'b10, HANDOFF = 2'b11} state_t;
  state_t        r_state;
  logic          r_comp_prev, r_dir, r_rail, r_sat_hi, r_sat_lo;
  logic [TW-1:0] r_tog_cnt;
  logic [SW-1:0] r_set_cnt;
  logic [AW-1:0] r_sat_cnt;
  logic          w_sat_hi, w_sat_lo, w_at_rail;
  logic [TW-1:0] w_tog_nxt;
  logic [AW-1:0] w_sat_nxt;
  assign w_sat_hi  = &fine_out;
  assign w_sat_lo  = ~|fine_out;
  assign w_at_rail = w_sat_hi ? &coarse_out : ~|coarse_out;
  assign w_tog_nxt = (r_tog_cnt == TOG_MAX) ? r_tog_cnt : r_tog_cnt + 1'b1;
  // a flip of saturation direction restarts the run at one
  assign w_sat_nxt = (r_sat_cnt != '0 && w_sat_hi != r_dir) ? AW'(1) :
                     (r_sat_cnt == SAT_MAX) ? r_sat_cnt : r_sat_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COARSE;
      r_comp_prev <= 1'b0;
      r_dir       <= 1'b0;
      r_rail      <= 1'b0;
      r_sat_hi    <= 1'b0;
      r_sat_lo    <= 1'b0;
      r_tog_cnt   <= '0;
      r_set_cnt   <= '0;
      r_sat_cnt   <= '0;
    end else begin
      r_sat_hi <= w_sat_hi;
      r_sat_lo <= w_sat_lo;
      case (r_state)
        COARSE: begin
          r_comp_prev <= comp_in;
          if (comp_in == r_comp_prev) r_tog_cnt <= '0;
          else if (w_tog_nxt == TOG_MAX) begin
            r_state   <= SETTLE;
            r_tog_cnt <= '0;
          end else r_tog_cnt <= w_tog_nxt;
        end
        SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            r_state   <= FINE;
            r_set_cnt <= '0;
          end else r_set_cnt <= r_set_cnt + 1'b1;
        end
        FINE: begin
          if (w_sat_hi | w_sat_lo) begin
            r_dir <= w_sat_hi;
            if (w_sat_nxt == SAT_MAX) begin
              r_sat_cnt <= '0;
              if (w_at_rail) r_rail <= 1'b1;
              else r_state <= HANDOFF;
            end else r_sat_cnt <= w_sat_nxt;
          end else r_sat_cnt <= '0;
        end
        default: r_state <= SETTLE;
      endcase
    end
  end
  assign state     = r_state;
  assign coarse_en = (r_state == COARSE) || (r_state == HANDOFF);
  assign fine_en   = (r_state == FINE);
  assign up        = (r_state == HANDOFF) & r_dir;
  assign lock      = (r_state == FINE) & ~r_sat_hi & ~r_sat_lo;
  assign rail      = r_rail;
endmodule
